digota_ctrl: RTL

Clocked front-end that produces the `INpb`/`INmb`/`oe` drive code for the downstream DIGOTA output-stage decoder. It synchronises the two raw asynchronous comparator outputs, rejects glitches with a consecutive-sample filter, and enforces a break-before-make dead time: `oe` is held low whenever the drive code changes. It also counts direction switches for characterisation.

---
 rtl/digota_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/digota_ctrl.sv
`default_nettype none
// ============================================================================
// Module : digota_ctrl
// Comparator synchroniser, glitch filter and break-before-make sequencer
// producing INpb/INmb/oe for the DIGOTA output-stage decoder.
// Rev    : 1.0
// ============================================================================
module digota_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int DEAD_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cmp_p,
  input  logic       cmp_m,
  input  logic       cnt_clr,
  output logic       INpb,
  output logic       INmb,
  output logic       oe,
  output logic       dead,
  output logic [7:0] sw_cnt
);

  localparam logic [3:0] c_FILT_LEN = 4'(FILT_LEN);
  localparam logic [3:0] c_DEAD_CYC = 4'(DEAD_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEAD  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync_p;
  logic [SYNC_STAGES-1:0] r_sync_m;
  logic [1:0]             w_sync;

  logic [1:0] r_cand;
  logic [3:0] r_run;
  logic [3:0] w_run_inc;
  logic [1:0] r_filt;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_code;
  logic [1:0] w_code_nxt;
  logic [3:0] r_dc;
  logic [3:0] w_dc_nxt;
  logic       w_inc;
  logic       r_oe;
  logic       r_dead;
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p <= '0;
      r_sync_m <= '0;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], cmp_p};
      r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], cmp_m};
    end
  end

  assign w_sync    = {r_sync_p[SYNC_STAGES-1], r_sync_m[SYNC_STAGES-1]};
  assign w_run_inc = (r_run == c_FILT_LEN) ? r_run : r_run + 4'd1;

  // run counts consecutive identical samples of cand; filt only accepts a full run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= 2'b00;
      r_run  <= 4'd0;
      r_filt <= 2'b00;
    end else if (w_sync != r_cand) begin
      r_cand <= w_sync;
      r_run  <= 4'd1;
    end else begin
      r_run <= w_run_inc;
      if (w_run_inc == c_FILT_LEN) begin
        r_filt <= r_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_dc_nxt    = r_dc;
    w_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_code_nxt = 2'b00;
        if (en) begin
          w_code_nxt  = r_filt;
          w_dc_nxt    = c_DEAD_CYC;
          w_state_nxt = S_DEAD;
        end
      end
      S_DEAD: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = 2'b00;
        end else if (r_filt != r_code) begin
          w_code_nxt = r_filt;
          w_dc_nxt   = c_DEAD_CYC;
        end else if (r_dc == 4'd1) begin
          w_state_nxt = S_DRIVE;
        end else begin
          w_dc_nxt = r_dc - 4'd1;
        end
      end
      S_DRIVE: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = 2'b00;
        end else if (r_filt != r_code) begin
          w_state_nxt = S_DEAD;
          w_code_nxt  = r_filt;
          w_dc_nxt    = c_DEAD_CYC;
          w_inc       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = 2'b00;
      end
    endcase
  end

  // oe/dead are registered from the next state so they align with r_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 2'b00;
      r_dc    <= 4'd0;
      r_oe    <= 1'b0;
      r_dead  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_dc    <= w_dc_nxt;
      r_oe    <= (w_state_nxt == S_DRIVE);
      r_dead  <= (w_state_nxt == S_DEAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (cnt_clr) begin
      r_cnt <= 8'd0;
    end else if (w_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign INpb   = r_code[1];
  assign INmb   = r_code[0];
  assign oe     = r_oe;
  assign dead   = r_dead;
  assign sw_cnt = r_cnt;

endmodule
`default_nettype wire
